alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 173 +++++++++++++++++
 tb/tb_alu_rs.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: six-entry ALU reservation station with dual CDB wakeup and dual issue.
// Defining ALU_RS_FLUSH_EN adds a flush that discards all entries and in-flight issues.
module alu_rs #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic [TAG_W-1:0]  disp_dest,
  output logic              rs_full,
  input  logic              cdb_a_valid,
  input  logic [TAG_W-1:0]  cdb_a_tag,
  input  logic [DATA_W-1:0] cdb_a_data,
  input  logic              cdb_b_valid,
  input  logic [TAG_W-1:0]  cdb_b_tag,
  input  logic [DATA_W-1:0] cdb_b_data,
  output logic [5:0]        alu_busy,
  output logic [5:0]        alu_ready,
  input  logic [2:0]        free_idx_1,
  input  logic [2:0]        free_idx_2,
  input  logic [2:0]        ready_idx_1,
  input  logic [2:0]        ready_idx_2,
  output logic              issue_1_valid,
  output logic [OP_W-1:0]   issue_1_op,
  output logic [DATA_W-1:0] issue_1_v1,
  output logic [DATA_W-1:0] issue_1_v2,
  output logic [TAG_W-1:0]  issue_1_dest,
  output logic              issue_2_valid,
  output logic [OP_W-1:0]   issue_2_op,
  output logic [DATA_W-1:0] issue_2_v1,
  output logic [DATA_W-1:0] issue_2_v2,
  output logic [TAG_W-1:0]  issue_2_dest
);
  localparam int         NENT      = 6;
  localparam logic [2:0] IDX_NONE  = 3'b111;
  localparam logic [2:0] IDX_LIMIT = 3'd6;

  logic [NENT-1:0]   r_busy;
  logic [OP_W-1:0]   r_op   [NENT];
  logic [DATA_W-1:0] r_v1   [NENT];
  logic [DATA_W-1:0] r_v2   [NENT];
  logic [TAG_W-1:0]  r_q1   [NENT];
  logic [TAG_W-1:0]  r_q2   [NENT];
  logic [TAG_W-1:0]  r_dest [NENT];

  logic              r_iss1_valid, r_iss2_valid;
  logic [OP_W-1:0]   r_iss1_op, r_iss2_op;
  logic [DATA_W-1:0] r_iss1_v1, r_iss1_v2, r_iss2_v1, r_iss2_v2;
  logic [TAG_W-1:0]  r_iss1_dest, r_iss2_dest;

  logic [NENT-1:0]   w_ready_n;
  logic              w_disp, w_iss1, w_iss2;

  // Resolve one operand against both result buses; bus a has priority.
  function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0]  q,
                                                   input logic [DATA_W-1:0] v);
    logic [TAG_W+DATA_W-1:0] res;
    res = {q, v};
    if (q != {TAG_W{1'b0}}) begin
      if (cdb_a_valid && (cdb_a_tag == q)) begin
        res = {{TAG_W{1'b0}}, cdb_a_data};
      end else if (cdb_b_valid && (cdb_b_tag == q)) begin
        res = {{TAG_W{1'b0}}, cdb_b_data};
      end else begin
        res = {q, v};
      end
    end
    return res;
  endfunction

  // Ready vector: zero bit marks an occupied entry whose operands are both present.
  always_comb begin
    w_ready_n = {NENT{1'b1}};
    for (int i = 0; i < NENT; i++) begin
      w_ready_n[i] = ~(r_busy[i] && (r_q1[i] == {TAG_W{1'b0}}) && (r_q2[i] == {TAG_W{1'b0}}));
    end
  end

  assign alu_busy  = r_busy;
  assign alu_ready = w_ready_n;
  assign rs_full   = (free_idx_2 == IDX_NONE);
  assign w_disp    = disp_valid && (free_idx_1 < IDX_LIMIT);
  assign w_iss1    = (ready_idx_1 < IDX_LIMIT);
  assign w_iss2    = (ready_idx_2 < IDX_LIMIT) && (ready_idx_2 != ready_idx_1);

`ifndef ALU_RS_FLUSH_EN
  logic w_unused_flush;
  assign w_unused_flush = flush;
`endif

  // Entry storage, wakeup, dispatch and the two issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NENT{1'b0}};
      for (int i = 0; i < NENT; i++) begin
        r_op[i]   <= {OP_W{1'b0}};
        r_v1[i]   <= {DATA_W{1'b0}};
        r_v2[i]   <= {DATA_W{1'b0}};
        r_q1[i]   <= {TAG_W{1'b0}};
        r_q2[i]   <= {TAG_W{1'b0}};
        r_dest[i] <= {TAG_W{1'b0}};
      end
      r_iss1_valid <= 1'b0;
      r_iss1_op    <= {OP_W{1'b0}};
      r_iss1_v1    <= {DATA_W{1'b0}};
      r_iss1_v2    <= {DATA_W{1'b0}};
      r_iss1_dest  <= {TAG_W{1'b0}};
      r_iss2_valid <= 1'b0;
      r_iss2_op    <= {OP_W{1'b0}};
      r_iss2_v1    <= {DATA_W{1'b0}};
      r_iss2_v2    <= {DATA_W{1'b0}};
      r_iss2_dest  <= {TAG_W{1'b0}};
`ifdef ALU_RS_FLUSH_EN
    end else if (flush) begin
      r_busy       <= {NENT{1'b0}};
      r_iss1_valid <= 1'b0;
      r_iss2_valid <= 1'b0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < NENT; i++) begin
        if (r_busy[i]) begin
          {r_q1[i], r_v1[i]} <= wake(r_q1[i], r_v1[i]);
          {r_q2[i], r_v2[i]} <= wake(r_q2[i], r_v2[i]);
        end
      end
      r_iss1_valid <= w_iss1;
      if (w_iss1) begin
        r_iss1_op           <= r_op[ready_idx_1];
        r_iss1_v1           <= r_v1[ready_idx_1];
        r_iss1_v2           <= r_v2[ready_idx_1];
        r_iss1_dest         <= r_dest[ready_idx_1];
        r_busy[ready_idx_1] <= 1'b0;
      end
      r_iss2_valid <= w_iss2;
      if (w_iss2) begin
        r_iss2_op           <= r_op[ready_idx_2];
        r_iss2_v1           <= r_v1[ready_idx_2];
        r_iss2_v2           <= r_v2[ready_idx_2];
        r_iss2_dest         <= r_dest[ready_idx_2];
        r_busy[ready_idx_2] <= 1'b0;
      end
      // A free slot is never the one being issued, so the two writes cannot collide.
      if (w_disp) begin
        r_busy[free_idx_1]                     <= 1'b1;
        r_op[free_idx_1]                       <= disp_op;
        r_dest[free_idx_1]                     <= disp_dest;
        {r_q1[free_idx_1], r_v1[free_idx_1]}   <= wake(disp_q1, disp_v1);
        {r_q2[free_idx_1], r_v2[free_idx_1]}   <= wake(disp_q2, disp_v2);
      end
    end
  end

  assign issue_1_valid = r_iss1_valid;
  assign issue_1_op    = r_iss1_op;
  assign issue_1_v1    = r_iss1_v1;
  assign issue_1_v2    = r_iss1_v2;
  assign issue_1_dest  = r_iss1_dest;
  assign issue_2_valid = r_iss2_valid;
  assign issue_2_op    = r_iss2_op;
  assign issue_2_v1    = r_iss2_v1;
  assign issue_2_v2    = r_iss2_v2;
  assign issue_2_dest  = r_iss2_dest;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic
// compared against an entry-level behavioural model of the reservation station.
module tb_alu_rs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic [5:0]  disp_op = 6'd0;
  logic [31:0] disp_v1 = 32'd0, disp_v2 = 32'd0;
  logic [3:0]  disp_q1 = 4'd0, disp_q2 = 4'd0, disp_dest = 4'd0;
  logic        rs_full;
  logic        cdb_a_valid = 1'b0, cdb_b_valid = 1'b0;
  logic [3:0]  cdb_a_tag = 4'd0, cdb_b_tag = 4'd0;
  logic [31:0] cdb_a_data = 32'd0, cdb_b_data = 32'd0;
  logic [5:0]  alu_busy, alu_ready;
  logic [2:0]  free_idx_1, free_idx_2, ready_idx_1, ready_idx_2;
  logic        issue_1_valid, issue_2_valid;
  logic [5:0]  issue_1_op, issue_2_op;
  logic [31:0] issue_1_v1, issue_1_v2, issue_2_v1, issue_2_v2;
  logic [3:0]  issue_1_dest, issue_2_dest;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic busy; logic [5:0] op; logic [31:0] v1; logic [3:0] q1;
    logic [31:0] v2; logic [3:0] q2; logic [3:0] dest;
  } ent_t;
  typedef struct packed {
    logic valid; logic [5:0] op; logic [31:0] v1; logic [31:0] v2; logic [3:0] dest;
  } iss_t;

  ent_t m [6];
  iss_t mi [2];
  iss_t d_iss1, d_iss2;
  assign d_iss1 = {issue_1_valid, issue_1_op, issue_1_v1, issue_1_v2, issue_1_dest};
  assign d_iss2 = {issue_2_valid, issue_2_op, issue_2_v1, issue_2_v2, issue_2_dest};

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_dest(disp_dest), .rs_full(rs_full),
    .cdb_a_valid(cdb_a_valid), .cdb_a_tag(cdb_a_tag), .cdb_a_data(cdb_a_data),
    .cdb_b_valid(cdb_b_valid), .cdb_b_tag(cdb_b_tag), .cdb_b_data(cdb_b_data),
    .alu_busy(alu_busy), .alu_ready(alu_ready),
    .free_idx_1(free_idx_1), .free_idx_2(free_idx_2),
    .ready_idx_1(ready_idx_1), .ready_idx_2(ready_idx_2),
    .issue_1_valid(issue_1_valid), .issue_1_op(issue_1_op), .issue_1_v1(issue_1_v1),
    .issue_1_v2(issue_1_v2), .issue_1_dest(issue_1_dest),
    .issue_2_valid(issue_2_valid), .issue_2_op(issue_2_op), .issue_2_v1(issue_2_v1),
    .issue_2_v2(issue_2_v2), .issue_2_dest(issue_2_dest)
  );

  always #5 clk = ~clk;

  // External lookup table: index of the n-th zero bit, 7 when there is none.
  function automatic logic [2:0] nth_zero(input logic [5:0] bits, input int n);
    int seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (!bits[i]) begin
        if (seen == n) return 3'(i);
        seen++;
      end
    end
    return 3'b111;
  endfunction

  assign free_idx_1  = nth_zero(alu_busy, 0);
  assign free_idx_2  = nth_zero(alu_busy, 1);
  assign ready_idx_1 = nth_zero(alu_ready, 0);
  assign ready_idx_2 = nth_zero(alu_ready, 1);

  function automatic void resolve(input logic [3:0] q, input logic [31:0] v,
                                  output logic [3:0] qo, output logic [31:0] vo);
    qo = q; vo = v;
    if (q != 4'd0 && cdb_a_valid && cdb_a_tag == q) begin qo = 4'd0; vo = cdb_a_data; end
    else if (q != 4'd0 && cdb_b_valid && cdb_b_tag == q) begin qo = 4'd0; vo = cdb_b_data; end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m[i] = '0;
    mi[0] = '0; mi[1] = '0;
  endfunction

  function automatic void model_edge();
    ent_t nx [6];
    int   rq [$];
    int   fr = -1;
`ifdef ALU_RS_FLUSH_EN
    if (flush) begin
      for (int i = 0; i < 6; i++) m[i].busy = 1'b0;
      mi[0].valid = 1'b0; mi[1].valid = 1'b0;
      return;
    end
`endif
    if (!rdy) return;
    nx = m;
    for (int i = 0; i < 6; i++) begin
      if (m[i].busy && m[i].q1 == 4'd0 && m[i].q2 == 4'd0) rq.push_back(i);
      if (!m[i].busy && fr < 0) fr = i;
      if (m[i].busy) begin
        resolve(m[i].q1, m[i].v1, nx[i].q1, nx[i].v1);
        resolve(m[i].q2, m[i].v2, nx[i].q2, nx[i].v2);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rq.size() > k) begin
        mi[k].valid = 1'b1; mi[k].op = m[rq[k]].op; mi[k].v1 = m[rq[k]].v1;
        mi[k].v2 = m[rq[k]].v2; mi[k].dest = m[rq[k]].dest;
        nx[rq[k]].busy = 1'b0;
      end else begin
        mi[k].valid = 1'b0;
      end
    end
    if (disp_valid && fr >= 0) begin
      nx[fr].busy = 1'b1; nx[fr].op = disp_op; nx[fr].dest = disp_dest;
      resolve(disp_q1, disp_v1, nx[fr].q1, nx[fr].v1);
      resolve(disp_q2, disp_v2, nx[fr].q2, nx[fr].v2);
    end
    m = nx;
  endfunction

  function automatic logic [5:0] e_busy();
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = m[i].busy;
    return r;
  endfunction

  function automatic logic [5:0] e_ready();
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = !(m[i].busy && m[i].q1 == 4'd0 && m[i].q2 == 4'd0);
    return r;
  endfunction

  function automatic logic e_full();
    int nfree = 0;
    for (int i = 0; i < 6; i++) if (!m[i].busy) nfree++;
    return (nfree < 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    cdb_a_valid = 1'b0; cdb_b_valid = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                      input logic [31:0] v2, input logic [3:0] q2, input logic [3:0] dest);
    disp_valid = 1'b1; disp_op = op; disp_v1 = v1; disp_q1 = q1;
    disp_v2 = v2; disp_q2 = q2; disp_dest = dest;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_checks++;
    if (alu_busy !== 6'b000000 || alu_ready !== 6'b111111 || rs_full !== 1'b0) begin
      n_fails++; $display("FAIL reset_state: busy %b ready %b full %b, want 000000 111111 0", alu_busy, alu_ready, rs_full);
    end
    n_checks++;
    if (d_iss1 !== '0 || d_iss2 !== '0) begin
      n_fails++; $display("FAIL reset_issue: iss1 %h iss2 %h, want 0", d_iss1, d_iss2);
    end
    do_reset();
  endtask

  task automatic test_basic();
    disp(6'h01, 32'd3, 4'd0, 32'd4, 4'd0, 4'd5);
    tick();
    disp_valid = 1'b0;
    n_checks++;
    if (alu_busy !== 6'b000001 || issue_1_valid !== 1'b0) begin
      n_fails++; $display("FAIL basic_dispatch: busy %b iss1v %b, want 000001 0", alu_busy, issue_1_valid);
    end
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || issue_1_v1 !== 32'd3 || issue_1_v2 !== 32'd4 ||
        issue_1_dest !== 4'd5 || issue_1_op !== 6'h01 || alu_busy !== 6'b000000) begin
      n_fails++; $display("FAIL basic_issue: v %b v1 %0d v2 %0d dest %0d busy %b, want 1 3 4 5 000000",
                          issue_1_valid, issue_1_v1, issue_1_v2, issue_1_dest, alu_busy);
    end
  endtask

  task automatic test_cdb_wake();
    disp(6'h02, 32'd0, 4'd7, 32'd9, 4'd0, 4'd1);
    tick();
    disp_valid = 1'b0;
    cdb_a_valid = 1'b1; cdb_a_tag = 4'd7; cdb_a_data = 32'h11;
    tick();
    cdb_a_valid = 1'b0;
    n_checks++;
    if (issue_1_valid !== 1'b0 || alu_ready !== 6'b111110) begin
      n_fails++; $display("FAIL wake_pending: iss1v %b ready %b, want 0 111110", issue_1_valid, alu_ready);
    end
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || issue_1_v1 !== 32'h11 || issue_1_v2 !== 32'd9) begin
      n_fails++; $display("FAIL wake_issue: v %b v1 %h v2 %0d, want 1 11 9", issue_1_valid, issue_1_v1, issue_1_v2);
    end
  endtask

  task automatic test_dispatch_capture();
    disp(6'h03, 32'd0, 4'd3, 32'd6, 4'd0, 4'd2);
    cdb_b_valid = 1'b1; cdb_b_tag = 4'd3; cdb_b_data = 32'h22;
    tick();
    disp_valid = 1'b0; cdb_b_valid = 1'b0;
    n_checks++;
    if (alu_ready !== 6'b111110) begin
      n_fails++; $display("FAIL capture_ready: ready %b, want 111110", alu_ready);
    end
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || issue_1_v1 !== 32'h22 || issue_1_dest !== 4'd2) begin
      n_fails++; $display("FAIL capture_issue: v %b v1 %h dest %0d, want 1 22 2", issue_1_valid, issue_1_v1, issue_1_dest);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 7; i++) begin
      disp(6'(i), 32'(i), 4'd9, 32'(i + 100), 4'd0, 4'(i + 1));
      tick();
      if (i == 3) begin
        n_checks++;
        if (rs_full !== 1'b0) begin n_fails++; $display("FAIL full_four: full %b, want 0", rs_full); end
      end
      if (i == 4) begin
        n_checks++;
        if (rs_full !== 1'b1 || alu_busy !== 6'b011111) begin
          n_fails++; $display("FAIL full_five: full %b busy %b, want 1 011111", rs_full, alu_busy);
        end
      end
    end
    disp_valid = 1'b0;
    n_checks++;
    if (alu_busy !== 6'b111111 || e_busy() !== 6'b111111 || m[5].dest !== 4'd6) begin
      n_fails++; $display("FAIL full_drop: busy %b, want 111111", alu_busy);
    end
    cdb_a_valid = 1'b1; cdb_a_tag = 4'd9; cdb_a_data = 32'hABCD;
    tick();
    cdb_a_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (d_iss1 !== mi[0] || d_iss2 !== mi[1]) begin
        n_fails++; $display("FAIL full_drain %0d: iss1 %h iss2 %h, want %h %h", c, d_iss1, d_iss2, mi[0], mi[1]);
      end
    end
    n_checks++;
    if (alu_busy !== 6'b000000) begin n_fails++; $display("FAIL full_empty: busy %b, want 000000", alu_busy); end
  endtask

  task automatic test_dual_issue_rdy();
    logic [3:0] tg [5];
    tg[0] = 4'd10; tg[1] = 4'd10; tg[2] = 4'd11; tg[3] = 4'd10; tg[4] = 4'd11;
    for (int i = 0; i < 5; i++) begin
      disp(6'h04, 32'(i * 7), tg[i], 32'(i), 4'd0, 4'(i));
      tick();
    end
    disp_valid = 1'b0;
    cdb_a_valid = 1'b1; cdb_a_tag = 4'd11; cdb_a_data = 32'h5A;
    tick();
    cdb_a_valid = 1'b0;
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || issue_1_dest !== 4'd2 || issue_2_valid !== 1'b1 ||
        issue_2_dest !== 4'd4 || issue_2_v1 !== 32'h5A) begin
      n_fails++; $display("FAIL dual_issue: v1 %b d1 %0d v2 %b d2 %0d i2v1 %h, want 1 2 1 4 5a",
                          issue_1_valid, issue_1_dest, issue_2_valid, issue_2_dest, issue_2_v1);
    end
    rdy = 1'b0;
    disp(6'h05, 32'd1, 4'd0, 32'd1, 4'd0, 4'd1);
    cdb_a_valid = 1'b1; cdb_a_tag = 4'd10; cdb_a_data = 32'h77;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (alu_busy !== 6'b001011 || alu_ready !== 6'b111111 || issue_1_valid !== 1'b1 ||
          issue_1_dest !== 4'd2 || issue_2_valid !== 1'b1 || issue_2_dest !== 4'd4) begin
        n_fails++; $display("FAIL rdy_hold %0d: busy %b ready %b i1 %b/%0d i2 %b/%0d, want 001011 111111 1/2 1/4",
                            c, alu_busy, alu_ready, issue_1_valid, issue_1_dest, issue_2_valid, issue_2_dest);
      end
    end
    idle();
    cdb_a_valid = 1'b1; cdb_a_tag = 4'd10; cdb_a_data = 32'h77;
    tick();
    cdb_a_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (d_iss1 !== mi[0] || d_iss2 !== mi[1] || alu_busy !== e_busy()) begin
        n_fails++; $display("FAIL rdy_drain %0d: iss1 %h iss2 %h busy %b, want %h %h %b",
                            c, d_iss1, d_iss2, alu_busy, mi[0], mi[1], e_busy());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      disp(6'h06, 32'd0, 4'd13, 32'd0, 4'd0, 4'(i));
      tick();
    end
    disp(6'h07, 32'd8, 4'd0, 32'd8, 4'd0, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
`ifdef ALU_RS_FLUSH_EN
    n_checks++;
    if (alu_busy !== 6'b000000 || issue_1_valid !== 1'b0 || issue_2_valid !== 1'b0) begin
      n_fails++; $display("FAIL flush_clear: busy %b i1v %b i2v %b, want 000000 0 0", alu_busy, issue_1_valid, issue_2_valid);
    end
`else
    n_checks++;
    if (alu_busy !== 6'b011111) begin
      n_fails++; $display("FAIL flush_ignored: busy %b, want 011111", alu_busy);
    end
`endif
    cdb_b_valid = 1'b1; cdb_b_tag = 4'd13; cdb_b_data = 32'h99;
    tick();
    cdb_b_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (alu_busy !== 6'b000000 || alu_busy !== e_busy()) begin
      n_fails++; $display("FAIL flush_drain: busy %b, want 000000", alu_busy);
    end
  endtask

  task automatic test_reset_mid();
    disp(6'h08, 32'd1, 4'd12, 32'd2, 4'd0, 4'd3);
    tick();
    disp(6'h09, 32'd5, 4'd0, 32'd6, 4'd0, 4'd4);
    tick();
    disp_valid = 1'b0;
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || alu_busy !== 6'b000001) begin
      n_fails++; $display("FAIL mid_setup: i1v %b busy %b, want 1 000001", issue_1_valid, alu_busy);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (alu_busy !== 6'b000000 || alu_ready !== 6'b111111 || issue_1_valid !== 1'b0 || issue_1_dest !== 4'd0) begin
      n_fails++; $display("FAIL mid_reset: busy %b ready %b i1v %b dest %0d, want 000000 111111 0 0",
                          alu_busy, alu_ready, issue_1_valid, issue_1_dest);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    disp(6'h0A, 32'd7, 4'd0, 32'd8, 4'd0, 4'd9);
    tick();
    disp_valid = 1'b0;
    n_checks++;
    if (alu_busy !== 6'b000001) begin n_fails++; $display("FAIL post_reset_disp: busy %b, want 000001", alu_busy); end
    tick();
    n_checks++;
    if (issue_1_valid !== 1'b1 || issue_1_dest !== 4'd9) begin
      n_fails++; $display("FAIL post_reset_issue: v %b dest %0d, want 1 9", issue_1_valid, issue_1_dest);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rdy         = ($urandom_range(0, 7) != 0);
      disp_valid  = 1'($urandom_range(0, 1));
      disp_op     = 6'($urandom);
      disp_v1     = $urandom;
      disp_v2     = $urandom;
      disp_q1     = 4'($urandom_range(0, 3));
      disp_q2     = 4'($urandom_range(0, 3));
      disp_dest   = 4'($urandom);
      cdb_a_valid = 1'($urandom_range(0, 1));
      cdb_a_tag   = 4'($urandom_range(0, 3));
      cdb_a_data  = $urandom;
      cdb_b_valid = 1'($urandom_range(0, 1));
      cdb_b_tag   = 4'($urandom_range(0, 3));
      cdb_b_data  = $urandom;
      tick();
      n_checks++;
      if (alu_busy !== e_busy() || alu_ready !== e_ready() || rs_full !== e_full()) begin
        n_fails++; $display("FAIL rand_state %0d: busy %b ready %b full %b, want %b %b %b",
                            c, alu_busy, alu_ready, rs_full, e_busy(), e_ready(), e_full());
      end
      n_checks++;
      if (d_iss1 !== mi[0] || d_iss2 !== mi[1]) begin
        n_fails++; $display("FAIL rand_issue %0d: iss1 %h iss2 %h, want %h %h", c, d_iss1, d_iss2, mi[0], mi[1]);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_cdb_wake();
    test_dispatch_capture();
    test_full();
    test_dual_issue_rdy();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
